// File: rtl/sequenciador_exibicao.sv
// Replays the stored game sequence onto the LEDs with timed on/off phases, then pulses pronto.
// Optional macro SEQ_EXIB_APAGA_FINAL_EN: the last entry also gets a dark phase before FIM.
module sequenciador_exibicao #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned T_ON   = 1000,
  parameter int unsigned T_OFF  = 500
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              parar,
  input  logic [ADDR_W-1:0] limite,
  input  logic              modo_rapido,
  input  logic [DATA_W-1:0] dado_memoria,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] leds,
  output logic              exibindo,
  output logic              pronto,
  output logic [2:0]        db_estado
);

  // Phase lengths clamped to at least one cycle so the timer always expires.
  localparam int unsigned TON_N  = (T_ON > 0) ? T_ON : 1;
  localparam int unsigned TOFF_N = (T_OFF > 0) ? T_OFF : 1;
  localparam int unsigned TON_R  = ((T_ON >> 1) > 0) ? (T_ON >> 1) : 1;
  localparam int unsigned TOFF_R = ((T_OFF >> 1) > 0) ? (T_OFF >> 1) : 1;
  localparam int unsigned TMAX   = (TON_N > TOFF_N) ? TON_N : TOFF_N;
  localparam int unsigned TW     = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StBusca   = 3'd1,
    StAceso   = 3'd2,
    StApagado = 3'd3,
    StProximo = 3'd4,
    StFim     = 3'd5
  } estado_e;

  estado_e           estado_q;
  logic [ADDR_W-1:0] limite_q;
  logic [TW-1:0]     ton_q;
  logic [TW-1:0]     toff_q;
  logic [TW-1:0]     timer_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= StIdle;
      limite_q <= '0;
      ton_q    <= '0;
      toff_q   <= '0;
      timer_q  <= '0;
      endereco <= '0;
      leds     <= '0;
      pronto   <= 1'b0;
    end else if (parar) begin
      estado_q <= StIdle;
      timer_q  <= '0;
      endereco <= '0;
      leds     <= '0;
      pronto   <= 1'b0;
    end else begin
      unique case (estado_q)
        StIdle: begin
          leds     <= '0;
          endereco <= '0;
          pronto   <= 1'b0;
          timer_q  <= '0;
          if (iniciar) begin
            limite_q <= limite;
            ton_q    <= modo_rapido ? TW'(TON_R) : TW'(TON_N);
            toff_q   <= modo_rapido ? TW'(TOFF_R) : TW'(TOFF_N);
            estado_q <= StBusca;
          end
        end
        // Address was presented a cycle earlier, so dado_memoria is valid here.
        StBusca: begin
          timer_q  <= '0;
          leds     <= dado_memoria;
          estado_q <= StAceso;
        end
        StAceso: begin
          if (timer_q == ton_q - TW'(1)) begin
            timer_q <= '0;
            leds    <= '0;
`ifdef SEQ_EXIB_APAGA_FINAL_EN
            estado_q <= StApagado;
`else
            if (endereco != limite_q) begin
              estado_q <= StApagado;
            end else begin
              estado_q <= StFim;
              pronto   <= 1'b1;
            end
`endif
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StApagado: begin
          leds <= '0;
          if (timer_q == toff_q - TW'(1)) begin
            timer_q <= '0;
            if (endereco == limite_q) begin
              estado_q <= StFim;
              pronto   <= 1'b1;
            end else begin
              estado_q <= StProximo;
              endereco <= endereco + ADDR_W'(1);
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StProximo: begin
          timer_q  <= '0;
          estado_q <= StBusca;
        end
        StFim: begin
          pronto   <= 1'b0;
          leds     <= '0;
          endereco <= '0;
          estado_q <= StIdle;
        end
        default: begin
          estado_q <= StIdle;
          pronto   <= 1'b0;
          leds     <= '0;
          endereco <= '0;
        end
      endcase
    end
  end

  assign exibindo  = (estado_q != StIdle);
  assign db_estado = estado_q;

endmodule

// File: tb/tb_sequenciador_exibicao.sv
// Randomized bench: each playback is compared cycle by cycle against a trace built from the
// phase rules (on/off lengths, per-entry phases, final pronto) with a synchronous-read memory.
module tb_sequenciador_exibicao;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned T_ON   = 4;
  localparam int unsigned T_OFF  = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              iniciar;
  logic              parar;
  logic [ADDR_W-1:0] limite;
  logic              modo_rapido;
  logic [DATA_W-1:0] dado_memoria = '0;
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] leds;
  logic              exibindo;
  logic              pronto;
  logic [2:0]        db_estado;

  logic [DATA_W-1:0] mem [16];
  logic [15:0]       exp_q[$];
  int                checks = 0;
  int                errors = 0;

  sequenciador_exibicao #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .T_ON  (T_ON),
    .T_OFF (T_OFF)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .parar       (parar),
    .limite      (limite),
    .modo_rapido (modo_rapido),
    .dado_memoria(dado_memoria),
    .endereco    (endereco),
    .leds        (leds),
    .exibindo    (exibindo),
    .pronto      (pronto),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  // Synchronous-read memory, one cycle of latency.
  always @(posedge clock) dado_memoria <= mem[endereco];

  function automatic logic [15:0] vec(input int st, input bit ex, input bit pr, input int en,
                                      input logic [DATA_W-1:0] ld);
    return {3'b000, 3'(st), ex, pr, 4'(en), ld};
  endfunction

  function automatic logic [15:0] observed();
    return {3'b000, db_estado, exibindo, pronto, endereco, leds};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got st=%0d ex=%0b pr=%0b en=%0d leds=%b want st=%0d ex=%0b pr=%0b en=%0d leds=%b",
               tag, $time, obs[12:10], obs[9], obs[8], obs[7:4], obs[3:0],
               exp[12:10], exp[9], exp[8], exp[7:4], exp[3:0]);
    end
  endtask

  // Expected cycle-by-cycle outputs of one full playback, starting at the first cycle after start.
  task automatic build(input int lim, input bit rapido);
    int ton;
    int toff;
    ton  = rapido ? (((T_ON / 2) > 0) ? T_ON / 2 : 1) : T_ON;
    toff = rapido ? (((T_OFF / 2) > 0) ? T_OFF / 2 : 1) : T_OFF;
    exp_q.delete();
    for (int i = 0; i <= lim; i++) begin
      exp_q.push_back(vec(1, 1'b1, 1'b0, i, '0));
      repeat (ton) exp_q.push_back(vec(2, 1'b1, 1'b0, i, mem[i]));
      if (i < lim) begin
        repeat (toff) exp_q.push_back(vec(3, 1'b1, 1'b0, i, '0));
        exp_q.push_back(vec(4, 1'b1, 1'b0, i + 1, '0));
      end
    end
`ifdef SEQ_EXIB_APAGA_FINAL_EN
    repeat (toff) exp_q.push_back(vec(3, 1'b1, 1'b0, lim, '0));
`endif
    exp_q.push_back(vec(5, 1'b1, 1'b1, lim, '0));
  endtask

  // Called at a negedge with the DUT idle; limite/modo_rapido are scrambled after the start.
  task automatic run(input string tag, input int lim, input bit rapido, input int abort_at,
                     input int hold);
    int n;
    build(lim, rapido);
    if (abort_at >= 0 && abort_at < exp_q.size()) begin
      while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
    end
    exp_q.push_back(vec(0, 1'b0, 1'b0, 0, '0));
    exp_q.push_back(vec(0, 1'b0, 1'b0, 0, '0));
    n = exp_q.size();
    limite      = ADDR_W'(lim);
    modo_rapido = rapido;
    iniciar     = 1'b1;
    parar       = 1'b0;
    @(negedge clock);
    for (int c = 0; c < n; c++) begin
      check(tag, observed(), exp_q[c]);
      iniciar     = (c < hold) && (abort_at < 0 || c < abort_at);
      parar       = (c == abort_at);
      limite      = ADDR_W'($urandom);
      modo_rapido = 1'($urandom);
      @(negedge clock);
    end
    iniciar = 1'b0;
    parar   = 1'b0;
  endtask

  initial begin
    int lim;
    int len;
    for (int i = 0; i < 16; i++) mem[i] = DATA_W'(1 << (i % 4));
    reset       = 1'b1;
    iniciar     = 1'b0;
    parar       = 1'b0;
    limite      = '0;
    modo_rapido = 1'b0;
    #12;
    check("reset", observed(), vec(0, 1'b0, 1'b0, 0, '0));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Asynchronous reset in the middle of a lit phase.
    limite  = 4'd3;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("pre_rst", observed(), vec(2, 1'b1, 1'b0, 0, mem[0]));
    reset = 1'b1;
    #1;
    check("rst_async", observed(), vec(0, 1'b0, 1'b0, 0, '0));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run("lim0", 0, 1'b0, -1, 0);
    run("lim2", 2, 1'b0, -1, 0);
    run("lim2_fast", 2, 1'b1, -1, 0);
    // Abort in the second dark phase, with iniciar held early in playback.
    run("abort", 2, 1'b0, 13, 3);

    iniciar = 1'b1;
    parar   = 1'b1;
    @(negedge clock);
    check("parar_wins", observed(), vec(0, 1'b0, 1'b0, 0, '0));
    iniciar = 1'b0;
    parar   = 1'b0;
    @(negedge clock);

    run("lim15", 15, 1'b0, -1, 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = DATA_W'($urandom);
      lim = int'($urandom_range(0, 6));
      build(lim, 1'(r));
      len = exp_q.size();
      run("rand", lim, 1'(r), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, len - 1)) : -1,
          int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
